// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver: 2-FF synchroniser, mid-bit 3-sample majority vote,
// one-cycle rx_done / frame_err pulses.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (BAUD_DIV < 8) begin : g_bad_div
    $error("uart_byte_rx: BAUD_DIV must be at least 8");
  end

  logic             sync_q;
  logic             rx_s;
  logic             rx_s_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       smp_q, smp_d;
  logic [7:0]       rx_data_d;
  logic             rx_done_d;
  logic             rx_state_d;
  logic             frame_err_d;

  logic fall;
  logic at_wrap;
  logic at_eval;
  logic sample;

  assign fall    = rx_s_d & ~rx_s;
  assign at_wrap = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
  assign at_eval = (baud_cnt_q == CNT_W'(HALF + 1));
  // Third vote is the live synchronised line on the evaluation cycle.
  assign sample  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = at_wrap ? '0 : CNT_W'(baud_cnt_q + 1'b1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    smp_d       = smp_q;
    rx_data_d   = rx_data;
    rx_done_d   = 1'b0;
    rx_state_d  = rx_state;
    frame_err_d = 1'b0;

    if (baud_cnt_q == CNT_W'(HALF - 1)) smp_d[0] = rx_s;
    if (baud_cnt_q == CNT_W'(HALF))     smp_d[1] = rx_s;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (fall) begin
          state_d    = START;
          rx_state_d = 1'b1;
        end
      end
      START: begin
        if (at_eval && sample) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          rx_state_d = 1'b0;
        end else if (at_wrap) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (at_eval) shift_d = {sample, shift_q[7:1]};
        if (at_wrap) begin
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (at_eval) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          rx_state_d = 1'b0;
          if (sample) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        rx_state_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q     <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      smp_q      <= 2'b11;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
      rx_state   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= rs232_rx;
      rx_s       <= sync_q;
      rx_s_d     <= rx_s;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      smp_q      <= smp_d;
      rx_data    <= rx_data_d;
      rx_done    <= rx_done_d;
      rx_state   <= rx_state_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: default-rate instance with exact latency
// scoreboard, plus a fast-rate instance for a 256-byte serial stream.
module tb_uart_byte_rx;

  localparam int D    = 434;
  localparam int HALF = 217;
  // 3 cycles from line change to first START cycle (2 sync FFs + edge FF).
  localparam int LAT  = 3 + 9 * D + HALF + 2;
  localparam int D2   = 8;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_state, frame_err;

  logic       lb_line = 1'b1;
  logic [7:0] lb_data;
  logic       lb_done, lb_state, lb_ferr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lb_rx_cnt = 0;
  exp_t exp_q[$];
  int   ferr_q[$];
  logic [7:0] lb_q[$];
  exp_t e_m;
  int   f_m;
  logic [7:0] l_m;

  uart_byte_rx u_dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rs232_rx (rs232_rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_state (rx_state),
    .frame_err(frame_err)
  );

  uart_byte_rx #(.CLK_FREQ(800), .BAUD_RATE(100)) u_lb (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rs232_rx (lb_line),
    .rx_data  (lb_data),
    .rx_done  (lb_done),
    .rx_state (lb_state),
    .frame_err(lb_ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one frame starting at a negedge; spike flips the line for one cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    if (stop_bit) exp_q.push_back('{b, cyc + LAT});
    else          ferr_q.push_back(cyc + LAT);
    for (int c = 0; c < 10 * D; c++) begin
      rs232_rx = fr[4'(c / D)] ^ (c == spike);
      @(negedge clk);
      if (c % D == D / 2) chk("rx_state_in_frame", 32'(rx_state), 32'd1);
    end
  endtask

  task automatic send_lb(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    lb_q.push_back(b);
    for (int c = 0; c < 10 * D2; c++) begin
      lb_line = fr[4'(c / D2)];
      @(negedge clk);
    end
  endtask

  // Scoreboard side for the default-rate instance.
  always @(negedge clk) begin
    if (rx_done || frame_err) chk("done_ferr_exclusive", 32'(rx_done & frame_err), 32'd0);
    if (rx_done) begin
      chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e_m = exp_q.pop_front();
        chk("rx_data_at_done", 32'(rx_data), 32'(e_m.data));
        chk("done_cycle", 32'(cyc), 32'(e_m.cyc));
        chk("rx_state_low_at_done", 32'(rx_state), 32'd0);
      end
    end
    if (frame_err) begin
      chk("ferr_expected", 32'(ferr_q.size() > 0), 32'd1);
      if (ferr_q.size() > 0) begin
        f_m = ferr_q.pop_front();
        chk("ferr_cycle", 32'(cyc), 32'(f_m));
      end
    end
  end

  always @(negedge clk) begin
    if (lb_ferr) chk("lb_frame_err", 32'(lb_ferr), 32'd0);
    if (lb_done) begin
      chk("lb_done_expected", 32'(lb_q.size() > 0), 32'd1);
      if (lb_q.size() > 0) begin
        l_m = lb_q.pop_front();
        chk("lb_data", 32'(lb_data), 32'(l_m));
        lb_rx_cnt++;
      end
    end
  end

  initial begin
    // Reset with idle line.
    repeat (50) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_rx_state", 32'(rx_state), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst_in = 1'b0;
    repeat (20) @(negedge clk);

    // Single byte with exact latency.
    send_frame(8'hAA, 1'b1, -1);
    rs232_rx = 1'b1;
    chk("aa_data", 32'(rx_data), 32'hAA);
    repeat (D) @(negedge clk);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hA5, 1'b1, -1);
    rs232_rx = 1'b1;
    chk("b2b_last_data", 32'(rx_data), 32'hA5);
    repeat (D) @(negedge clk);

    // Short low pulse: false start, no pulses.
    rs232_rx = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_state_high", 32'(rx_state), 32'd1);
    repeat (50) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (HALF + 10) @(negedge clk);
    chk("glitch_state_low", 32'(rx_state), 32'd0);
    chk("glitch_data_held", 32'(rx_data), 32'hA5);
    repeat (D) @(negedge clk);

    // One-cycle spike on the centre sample of data bit 3.
    send_frame(8'h0F, 1'b1, 4 * D + HALF + 1);
    rs232_rx = 1'b1;
    chk("spike_data", 32'(rx_data), 32'h0F);
    repeat (D) @(negedge clk);

    // Stop bit low, line held low, then recovery with a good frame.
    send_frame(8'h3C, 1'b0, -1);
    repeat (2 * D) @(negedge clk);
    chk("ferr_data_held", 32'(rx_data), 32'h0F);
    chk("ferr_state_idle", 32'(rx_state), 32'd0);
    rs232_rx = 1'b1;
    repeat (D) @(negedge clk);
    send_frame(8'hC3, 1'b1, -1);
    rs232_rx = 1'b1;
    chk("recover_data", 32'(rx_data), 32'hC3);
    repeat (D) @(negedge clk);

    // Reset mid-frame: frame is discarded, no rx_done.
    rs232_rx = 1'b0;
    repeat (3 * D) @(negedge clk);
    chk("midrst_state_before", 32'(rx_state), 32'd1);
    rs232_rx = 1'b1;
    rst_in = 1'b1;
    @(negedge clk);
    chk("midrst_state_after", 32'(rx_state), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'h00);
    rst_in = 1'b0;
    repeat (10 * D) @(negedge clk);
    chk("midrst_state_idle", 32'(rx_state), 32'd0);

    // Fast-rate stream of every byte value.
    for (int i = 0; i < 256; i++) send_lb(8'(i));
    lb_line = 1'b1;
    repeat (4 * D2) @(negedge clk);
    chk("lb_count", 32'(lb_rx_cnt), 32'd256);
    chk("lb_state_idle", 32'(lb_state), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ferr_q_drained", 32'(ferr_q.size()), 32'd0);
    chk("lb_q_drained", 32'(lb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
